// File: rtl/rv_alu_rf_pkg.sv
// rtl/rv_alu_rf_pkg.sv - shared widths and ALU opcode constants for the RV32I integer datapath
package rv_alu_rf_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] rnum_t;
  typedef logic [OP_W-1:0]   alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'd0;
  localparam alu_op_t ALU_SUB  = 5'd1;
  localparam alu_op_t ALU_SLL  = 5'd2;
  localparam alu_op_t ALU_SLT  = 5'd3;
  localparam alu_op_t ALU_SLTU = 5'd4;
  localparam alu_op_t ALU_XOR  = 5'd5;
  localparam alu_op_t ALU_SRL  = 5'd6;
  localparam alu_op_t ALU_SRA  = 5'd7;
  localparam alu_op_t ALU_OR   = 5'd8;
  localparam alu_op_t ALU_AND  = 5'd9;
endpackage

// File: rtl/rv_alu_rf_if.sv
// rtl/rv_alu_rf_if.sv - register file read/write ports and ALU operand/result bundle
interface rv_alu_rf_if;
  import rv_alu_rf_pkg::*;

  rnum_t   RNUM1;
  word_t   RDATA1;
  rnum_t   RNUM2;
  word_t   RDATA2;
  rnum_t   WNUM;
  word_t   WDATA;
  word_t   ALU_A;
  word_t   ALU_B;
  alu_op_t ALU_OP;
  word_t   ALU_Y;

  modport master (
    output RNUM1, RNUM2, WNUM, WDATA, ALU_A, ALU_B, ALU_OP,
    input  RDATA1, RDATA2, ALU_Y
  );

  modport slave (
    input  RNUM1, RNUM2, WNUM, WDATA, ALU_A, ALU_B, ALU_OP,
    output RDATA1, RDATA2, ALU_Y
  );
endinterface

// File: rtl/rv_alu_rf_regfile.sv
// rtl/rv_alu_rf_regfile.sv - 31 stored registers plus hardwired x0; RF_BYPASS_EN selects write-through reads
module rv_regfile
  import rv_alu_rf_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  rnum_t rnum1,
  output word_t rdata1,
  input  rnum_t rnum2,
  output word_t rdata2,
  input  rnum_t wnum,
  input  word_t wdata
);
  word_t regs [1:REG_CNT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wnum != '0) begin
      regs[wnum] <= wdata;
    end
  end

  function automatic word_t read_port(input rnum_t rnum);
    if (rnum == '0) return '0;
`ifdef RF_BYPASS_EN
    // WB result forwarded to ID in the same cycle it is written
    if (rnum == wnum) return wdata;
`endif
    return regs[rnum];
  endfunction

  always_comb begin
    rdata1 = read_port(rnum1);
    rdata2 = read_port(rnum2);
  end
endmodule

// File: rtl/rv_alu_rf.sv
// rtl/rv_alu_rf.sv - integer datapath top: register file plus combinational R-type ALU (RF_BYPASS_EN passes to the register file)
module rv_alu_rf
  import rv_alu_rf_pkg::*;
(
  input logic         CLK,
  input logic         RSTN,
  rv_alu_rf_if.slave  bus
);
  rv_regfile u_regfile (
    .clk    (CLK),
    .rst_n  (RSTN),
    .rnum1  (bus.RNUM1),
    .rdata1 (bus.RDATA1),
    .rnum2  (bus.RNUM2),
    .rdata2 (bus.RDATA2),
    .wnum   (bus.WNUM),
    .wdata  (bus.WDATA)
  );

  logic [4:0] shamt;
  assign shamt = bus.ALU_B[4:0];

  always_comb begin
    bus.ALU_Y = '0;
    unique case (bus.ALU_OP)
      ALU_ADD:  bus.ALU_Y = bus.ALU_A + bus.ALU_B;
      ALU_SUB:  bus.ALU_Y = bus.ALU_A - bus.ALU_B;
      ALU_SLL:  bus.ALU_Y = bus.ALU_A << shamt;
      ALU_SLT:  bus.ALU_Y = {31'd0, $signed(bus.ALU_A) < $signed(bus.ALU_B)};
      ALU_SLTU: bus.ALU_Y = {31'd0, bus.ALU_A < bus.ALU_B};
      ALU_XOR:  bus.ALU_Y = bus.ALU_A ^ bus.ALU_B;
      ALU_SRL:  bus.ALU_Y = bus.ALU_A >> shamt;
      ALU_SRA:  bus.ALU_Y = word_t'($signed(bus.ALU_A) >>> shamt);
      ALU_OR:   bus.ALU_Y = bus.ALU_A | bus.ALU_B;
      ALU_AND:  bus.ALU_Y = bus.ALU_A & bus.ALU_B;
      default:  bus.ALU_Y = '0;
    endcase
  end
endmodule

// File: tb/tb_rv_alu_rf.sv
// tb/tb_rv_alu_rf.sv - self-checking bench for rv_alu_rf (honours RF_BYPASS_EN)
module tb_rv_alu_rf;
  logic CLK;
  logic RSTN;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   cmp_en = 0;

  logic [31:0] model_rf [0:31];

  rv_alu_rf_if bus ();

  rv_alu_rf dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] n);
    if (n == 0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (n == bus.WNUM) return bus.WDATA;
`endif
    return model_rf[n];
  endfunction

  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    int unsigned sh;
    logic [63:0] ext;
    sh = b % 32;
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << sh;
      5'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4: return (a < b) ? 32'd1 : 32'd0;
      5'd5: return a ^ b;
      5'd6: return a >> sh;
      5'd7: begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      5'd8: return a | b;
      5'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge RSTN) for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

  always @(posedge CLK)
    if (RSTN && bus.WNUM != 0) model_rf[bus.WNUM] = bus.WDATA;

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cyc_rdata1", bus.RDATA1, model_read(bus.RNUM1));
      check("cyc_rdata2", bus.RDATA2, model_read(bus.RNUM2));
      check("cyc_alu_y", bus.ALU_Y, model_alu(bus.ALU_A, bus.ALU_B, bus.ALU_OP));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] y;
    string       name;
  } alu_vec_t;

  alu_vec_t vecs [$];

  initial begin
    vecs.push_back('{32'hFFFFFFFF, 32'h1,        5'd0,  32'h00000000, "add_wrap"});
    vecs.push_back('{32'h3,        32'h5,        5'd1,  32'hFFFFFFFE, "sub_neg"});
    vecs.push_back('{32'hFFFFFFFF, 32'h1,        5'd3,  32'h00000001, "slt"});
    vecs.push_back('{32'hFFFFFFFF, 32'h1,        5'd4,  32'h00000000, "sltu"});
    vecs.push_back('{32'h1,        32'd31,       5'd2,  32'h80000000, "sll_31"});
    vecs.push_back('{32'h1,        32'h21,       5'd2,  32'h00000002, "sll_mask"});
    vecs.push_back('{32'h80000000, 32'h4,        5'd6,  32'h08000000, "srl"});
    vecs.push_back('{32'h80000000, 32'h4,        5'd7,  32'hF8000000, "sra"});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'd5,  32'hFF00FF00, "xor"});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'd8,  32'hFFF0FFF0, "or"});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'd9,  32'h00F000F0, "and"});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'd15, 32'h00000000, "op15"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 5'd31, 32'h00000000, "op31"});

    RSTN = 1'b0;
    bus.RNUM1 = '0; bus.RNUM2 = '0; bus.WNUM = '0; bus.WDATA = '0;
    bus.ALU_A = '0; bus.ALU_B = '0; bus.ALU_OP = '0;
    #1;
    cmp_en = 1;
    repeat (3) tick();
    RSTN = 1'b1;

    for (int r = 1; r < 32; r++) begin
      bus.RNUM1 = r[4:0];
      bus.RNUM2 = 5'(32 - r);
      #1;
      check("reset_rd1", bus.RDATA1, 32'd0);
      check("reset_rd2", bus.RDATA2, 32'd0);
      tick();
    end

    bus.WNUM = 5'd0; bus.WDATA = 32'hDEADBEEF;
    tick();
    bus.RNUM1 = 5'd0;
    #1;
    check("x0_write", bus.RDATA1, 32'd0);

    bus.WNUM = 5'd5; bus.WDATA = 32'h12345678;
    tick();
    bus.WNUM = 5'd0;
    bus.RNUM1 = 5'd5; bus.RNUM2 = 5'd5;
    #1;
    check("x5_rd1", bus.RDATA1, 32'h12345678);
    check("x5_rd2", bus.RDATA2, 32'h12345678);
    tick();

    bus.WNUM = 5'd7; bus.WDATA = 32'hA5A5A5A5; bus.RNUM1 = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_before", bus.RDATA1, 32'hA5A5A5A5);
`else
    check("bypass_before", bus.RDATA1, 32'h00000000);
`endif
    tick();
    bus.WNUM = 5'd0;
    #1;
    check("bypass_after", bus.RDATA1, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      bus.ALU_A = vecs[i].a; bus.ALU_B = vecs[i].b; bus.ALU_OP = vecs[i].op;
      #1;
      check(vecs[i].name, bus.ALU_Y, vecs[i].y);
      tick();
    end

    for (int i = 0; i < 60; i++) begin
      bus.WNUM   = 5'($urandom_range(0, 31));
      bus.WDATA  = $urandom();
      bus.RNUM1  = (i % 4 == 0) ? bus.WNUM : 5'($urandom_range(0, 31));
      bus.RNUM2  = 5'($urandom_range(0, 31));
      bus.ALU_A  = (i % 3 == 0) ? 32'h80000000 | $urandom() : $urandom();
      bus.ALU_B  = $urandom();
      bus.ALU_OP = 5'($urandom_range(0, 12));
      tick();
    end

    bus.WNUM = 5'd5; bus.WDATA = 32'hCAFEF00D;
    tick();
    bus.WNUM = 5'd0; bus.RNUM1 = 5'd5;
    #1;
    check("pre_async_rst", bus.RDATA1, 32'hCAFEF00D);
    #1;
    RSTN = 1'b0;
    #1;
    check("async_rst", bus.RDATA1, 32'd0);
    tick();
    RSTN = 1'b1;
    tick();
    check("post_rst", bus.RDATA1, 32'd0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
